// File: rtl/d_lsu.sv
// d_lsu: data-bus load/store unit with byte-lane steering, store replication and load extension.
// Optional read timeout is compiled in with `define LSU_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | ready for a new request, bus idle
// RD_REQ    | one-cycle read request pulse
// RD_WAIT   | waiting for read data
// WR        | write request held until accepted
// DONE      | one-cycle completion with error flags
module d_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_LEN       = 14,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                lsu_req,
  input  logic                lsu_we,
  input  logic [2:0]          lsu_funct3,
  input  logic [XLEN-1:0]     lsu_addr,
  input  logic [XLEN-1:0]     lsu_wdata,
  output logic                lsu_ready,
  output logic                lsu_done,
  output logic [XLEN-1:0]     lsu_rdata,
  output logic                lsu_misalign,
  output logic                lsu_timeout,
  output logic [ADDR_LEN-1:0] d_addr,
  output logic                d_rd_req,
  input  logic                d_rd_ready,
  input  logic [XLEN-1:0]     d_rd_data,
  output logic                d_wr_req,
  input  logic                d_wr_ready,
  output logic [XLEN/8-1:0]   d_wr_be,
  output logic [XLEN-1:0]     d_wr_data
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]          state;
  logic [ADDR_LEN-1:0] addr_q;
  logic [2:0]          f3_q;
  logic [XLEN-1:0]     wdata_q;
  logic [XLEN-1:0]     rdata_q;
  logic                mis_q;
  logic                req_mis;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic [XLEN-1:0]     ld_fmt;
  logic [XLEN/8-1:0]   wr_be;
  logic [XLEN-1:0]     wr_data;
  logic                unused_addr;

  // Core address bits above the bus width are deliberately dropped.
  assign unused_addr = ^lsu_addr[XLEN-1:ADDR_LEN];

  always_comb begin
    req_mis = 1'b1;
    case (lsu_funct3)
      3'b000, 3'b100: req_mis = 1'b0;
      3'b001, 3'b101: req_mis = lsu_addr[0];
      3'b010:         req_mis = |lsu_addr[1:0];
      default:        req_mis = 1'b1;
    endcase
  end

  assign byte_sel = d_rd_data[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = d_rd_data[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_fmt = d_rd_data;
    case (f3_q)
      3'b000:  ld_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ld_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  ld_fmt = {24'd0, byte_sel};
      3'b101:  ld_fmt = {16'd0, half_sel};
      default: ld_fmt = d_rd_data;
    endcase
  end

  always_comb begin
    wr_be   = 4'hF;
    wr_data = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = 4'b0011 << addr_q[1:0];
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        wr_be   = 4'hF;
        wr_data = wdata_q;
      end
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_q;
  logic       tmo_hit;

  // Expiry on the last of TIMEOUT_CYCLES read cycles; a same-cycle response still wins.
  assign tmo_hit = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_req) begin
            addr_q  <= lsu_addr[ADDR_LEN-1:0];
            f3_q    <= lsu_funct3;
            wdata_q <= lsu_wdata;
            mis_q   <= req_mis;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
`endif
            if (req_mis)     state <= S_DONE;
            else if (lsu_we) state <= S_WR;
            else             state <= S_RD_REQ;
          end
        end
        S_RD_REQ, S_RD_WAIT: begin
          if (d_rd_ready) begin
            rdata_q <= ld_fmt;
            state   <= S_DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_hit) begin
            rdata_q <= '0;
            tmo_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
            state   <= S_RD_WAIT;
          end
`else
          else begin
            state <= S_RD_WAIT;
          end
`endif
        end
        S_WR: begin
          if (d_wr_ready) state <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
          mis_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
          tmo_q <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_ready    = (state == S_IDLE);
  assign lsu_done     = (state == S_DONE);
  assign lsu_misalign = lsu_done & mis_q;
  assign lsu_rdata    = rdata_q;
  assign d_rd_req     = (state == S_RD_REQ);
  assign d_wr_req     = (state == S_WR);
  // The RAM/register mux steers on the previous cycle's address, so hold it until IDLE.
  assign d_addr       = (state == S_IDLE) ? '0 : {addr_q[ADDR_LEN-1:2], 2'b00};
  assign d_wr_be      = d_wr_req ? wr_be : '0;
  assign d_wr_data    = d_wr_req ? wr_data : '0;

`ifdef LSU_TIMEOUT_EN
  assign lsu_timeout  = lsu_done & tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign lsu_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_d_lsu.sv
// Directed bench for d_lsu: loads, stores, misalignment, slow reads, reset mid-access,
// and the read timeout when LSU_TIMEOUT_EN is defined.
module tb_d_lsu;

  logic        clk;
  logic        rstb;
  logic        lsu_req;
  logic        lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_ready;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_misalign;
  logic        lsu_timeout;
  logic [13:0] d_addr;
  logic        d_rd_req;
  logic        d_rd_ready;
  logic [31:0] d_rd_data;
  logic        d_wr_req;
  logic        d_wr_ready;
  logic [3:0]  d_wr_be;
  logic [31:0] d_wr_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_rd;
  logic        got_mis;
  logic        got_tmo;
  logic [3:0]  got_be;
  logic [31:0] got_wd;
  int          done_at, n_rd, n_wr, n_done;
  logic        addr_ok;

  d_lsu #(.XLEN(32), .ADDR_LEN(14), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstb(rstb),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_misalign(lsu_misalign), .lsu_timeout(lsu_timeout),
    .d_addr(d_addr), .d_rd_req(d_rd_req), .d_rd_ready(d_rd_ready),
    .d_rd_data(d_rd_data), .d_wr_req(d_wr_req), .d_wr_ready(d_wr_ready),
    .d_wr_be(d_wr_be), .d_wr_data(d_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  // Issues one access and plays the bus side; lat is the response delay after the
  // read pulse, or the cycle index at which a write is accepted.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, input logic [31:0] rd);
    logic [31:0] ea;
    int rd_at;
    ea = {18'd0, addr[13:2], 2'b00};
    done_at = -1; n_rd = 0; n_wr = 0; addr_ok = 1'b1; rd_at = -1;
    got_rd = '0; got_mis = 1'b0; got_tmo = 1'b0; got_be = '0; got_wd = '0;
    check("ready_idle", {31'd0, lsu_ready}, 32'd1);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    for (int c = 1; c <= 60 && done_at < 0; c++) begin
      nxt;
      lsu_req = 1'b0; d_rd_ready = 1'b0; d_wr_ready = 1'b0; d_rd_data = 32'h0BAD0BAD;
      if (lsu_done) begin
        done_at = c; got_rd = lsu_rdata; got_mis = lsu_misalign; got_tmo = lsu_timeout;
      end else begin
        if (d_rd_req) begin
          n_rd++;
          if (rd_at < 0) rd_at = c;
        end
        if (d_wr_req) begin
          n_wr++; got_be = d_wr_be; got_wd = d_wr_data;
          if (c >= lat) d_wr_ready = 1'b1;
        end
        if ((n_rd + n_wr) > 0 && {18'd0, d_addr} != ea) addr_ok = 1'b0;
        if (rd_at > 0 && c == rd_at + lat) begin
          d_rd_ready = 1'b1; d_rd_data = rd;
        end
      end
    end
    nxt;
    check("idle_after", {30'd0, lsu_ready, lsu_done}, 32'd2);
  endtask

  initial begin
    rstb = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000;
    lsu_addr = '0; lsu_wdata = '0; d_rd_ready = 1'b1; d_rd_data = 32'h12345678;
    d_wr_ready = 1'b0;
    repeat (3) nxt;
    check("rst_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_flags", {28'd0, lsu_done, lsu_misalign, lsu_timeout, d_rd_req}, 32'd0);
    check("rst_wr_req", {31'd0, d_wr_req}, 32'd0);
    check("rst_addr", {18'd0, d_addr}, 32'd0);
    check("rst_be", {28'd0, d_wr_be}, 32'd0);
    check("rst_wdata", d_wr_data, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);
    rstb = 1'b1;
    // stale response after reset must be ignored
    nxt; nxt;
    check("stale_done", {31'd0, lsu_done}, 32'd0);
    check("stale_rdata", lsu_rdata, 32'd0);
    d_rd_ready = 1'b0;
    nxt;

    // LW from RAM, response one cycle after the request pulse
    access(1'b0, 3'b010, 32'h0000_2004, 32'd0, 1, 32'hDEADBEEF);
    check("lw_done_at", done_at, 32'd3);
    check("lw_rdata", got_rd, 32'hDEADBEEF);
    check("lw_mis", {31'd0, got_mis}, 32'd0);
    check("lw_nrd", n_rd, 32'd1);
    check("lw_addr", {31'd0, addr_ok}, 32'd1);
    check("lw_hold", lsu_rdata, 32'hDEADBEEF);

    // back-to-back load with upper core address bits set
    access(1'b0, 3'b000, 32'hFFFF_2003, 32'd0, 1, 32'h80FF1234);
    check("lb_rdata", got_rd, 32'hFFFFFF80);
    check("lb_addr", {31'd0, addr_ok}, 32'd1);
    access(1'b0, 3'b100, 32'h0000_2003, 32'd0, 1, 32'h80FF1234);
    check("lbu_rdata", got_rd, 32'h00000080);
    access(1'b0, 3'b001, 32'h0000_2002, 32'd0, 1, 32'h80FF1234);
    check("lh_rdata", got_rd, 32'hFFFF80FF);
    access(1'b0, 3'b101, 32'h0000_2000, 32'd0, 1, 32'h80FF9234);
    check("lhu_rdata", got_rd, 32'h00009234);
    access(1'b0, 3'b000, 32'h0000_2001, 32'd0, 0, 32'h80FF1234);
    check("lb_fast_at", done_at, 32'd2);
    check("lb_fast", got_rd, 32'h00000012);

    // stores
    access(1'b1, 3'b000, 32'h0000_2001, 32'hFFFF_FFA5, 1, 32'd0);
    check("sb_done_at", done_at, 32'd2);
    check("sb_be", {28'd0, got_be}, 32'h2);
    check("sb_wd", got_wd, 32'hA5A5A5A5);
    check("sb_addr", {31'd0, addr_ok}, 32'd1);
    access(1'b1, 3'b001, 32'h0000_2002, 32'hABCD_1234, 1, 32'd0);
    check("sh_done_at", done_at, 32'd2);
    check("sh_be", {28'd0, got_be}, 32'hC);
    check("sh_wd", got_wd, 32'h12341234);
    access(1'b1, 3'b010, 32'h0000_2008, 32'hCAFEF00D, 3, 32'd0);
    check("sw_done_at", done_at, 32'd4);
    check("sw_nwr", n_wr, 32'd3);
    check("sw_be", {28'd0, got_be}, 32'hF);
    check("sw_wd", got_wd, 32'hCAFEF00D);
    check("sw_addr", {31'd0, addr_ok}, 32'd1);

    // misaligned and illegal accesses: no bus cycle
    access(1'b0, 3'b010, 32'h0000_2002, 32'd0, 1, 32'h11111111);
    check("lw_mis_at", done_at, 32'd1);
    check("lw_mis_flag", {31'd0, got_mis}, 32'd1);
    check("lw_mis_bus", n_rd + n_wr, 32'd0);
    access(1'b1, 3'b001, 32'h0000_2001, 32'h1234, 1, 32'd0);
    check("sh_mis_at", done_at, 32'd1);
    check("sh_mis_flag", {31'd0, got_mis}, 32'd1);
    check("sh_mis_bus", n_rd + n_wr, 32'd0);
    access(1'b0, 3'b011, 32'h0000_2000, 32'd0, 1, 32'h11111111);
    check("ill_mis_flag", {31'd0, got_mis}, 32'd1);
    check("ill_mis_bus", n_rd + n_wr, 32'd0);

    // slow register read
    access(1'b0, 3'b010, 32'h0000_3F0C, 32'd0, 5, 32'h0C0FFEE0);
    check("slow_done_at", done_at, 32'd7);
    check("slow_nrd", n_rd, 32'd1);
    check("slow_addr", {31'd0, addr_ok}, 32'd1);
    check("slow_rdata", got_rd, 32'h0C0FFEE0);
    check("slow_tmo", {31'd0, got_tmo}, 32'd0);

`ifdef LSU_TIMEOUT_EN
    access(1'b0, 3'b010, 32'h0000_2010, 32'd0, 1000, 32'h0);
    check("tmo_done_at", done_at, 32'd5);
    check("tmo_flag", {31'd0, got_tmo}, 32'd1);
    check("tmo_rdata", got_rd, 32'd0);
    check("tmo_nrd", n_rd, 32'd1);
`endif

    // reset while waiting for read data abandons the access
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h0000_2014;
    nxt;
    lsu_req = 1'b0;
    check("rst_mid_rdreq", {31'd0, d_rd_req}, 32'd1);
    nxt; nxt;
    check("rst_mid_wait", {18'd0, d_addr}, 32'h2014);
    rstb = 1'b0;
    nxt;
    rstb = 1'b1;
    d_rd_ready = 1'b1; d_rd_data = 32'h55555555;
    check("rst_mid_ready", {31'd0, lsu_ready}, 32'd1);
    check("rst_mid_addr", {18'd0, d_addr}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      nxt;
      if (lsu_done) n_done++;
    end
    d_rd_ready = 1'b0;
    check("rst_mid_nodone", n_done, 32'd0);
    check("rst_mid_rdata", lsu_rdata, 32'd0);
    check("rst_mid_idle", {31'd0, lsu_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
